// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide,
// with a final sign-fixup step. One result bit per clock, fixed 34-cycle latency.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_mul,
    input  logic             op_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_RUN = 3'd1,
        DIV_RUN = 3'd2,
        FIXUP   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH - 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;      // mul: {partial sum, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd_reg;     // mul: |multiplicand|; div: |divisor|
    logic [WIDTH-1:0]     a_orig_reg;
    logic                 neg_res_reg;
    logic                 neg_rem_reg;
    logic                 is_div_reg;
    logic                 b_zero_reg;

    logic                 accept;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign accept = start && (op_mul ^ op_div);
    assign a_neg  = sign & a[WIDTH-1];
    assign b_neg  = sign & b[WIDTH-1];
    assign a_mag  = a_neg ? (~a + ONE_W) : a;
    assign b_mag  = b_neg ? (~b + ONE_W) : b;

    // Shift-add step: add multiplicand when multiplier LSB is set, then shift right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_next;
    assign mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one extra bit before the trial subtract.
    logic [WIDTH:0]       div_hi;
    logic [WIDTH+1:0]     div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_acc_next;
    assign div_hi       = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff     = {1'b0, div_hi} - {2'b00, opnd_reg};
    assign div_ok       = ~div_diff[WIDTH+1];
    assign div_acc_next = {(div_ok ? div_diff[WIDTH-1:0] : div_hi[WIDTH-1:0]),
                           acc_reg[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;
    assign prod_fix = neg_res_reg ? (~acc_reg + ONE_2W) : acc_reg;
    assign quot_fix = neg_res_reg ? (~acc_reg[WIDTH-1:0] + ONE_W) : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_rem_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + ONE_W) : acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = op_mul ? MUL_RUN : DIV_RUN;
            end
            MUL_RUN, DIV_RUN: begin
                busy = 1'b1;
                if (cnt_reg == LAST)
                    state_next = FIXUP;
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            a_orig_reg  <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            is_div_reg  <= 1'b0;
            b_zero_reg  <= 1'b0;
            div_zero    <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg     <= '0;
                        acc_reg     <= {{WIDTH{1'b0}}, (op_mul ? b_mag : a_mag)};
                        opnd_reg    <= op_mul ? a_mag : b_mag;
                        a_orig_reg  <= a;
                        neg_res_reg <= a_neg ^ b_neg;
                        neg_rem_reg <= a_neg;
                        is_div_reg  <= op_div;
                        b_zero_reg  <= (b == '0);
                    end
                end
                MUL_RUN: begin
                    acc_reg <= mul_acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                DIV_RUN: begin
                    acc_reg <= div_acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIXUP: begin
                    if (!is_div_reg) begin
                        hi_out   <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_out   <= prod_fix[WIDTH-1:0];
                        div_zero <= 1'b0;
                    end else if (b_zero_reg) begin
                        hi_out   <= a_orig_reg;
                        lo_out   <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi_out   <= rem_fix;
                        lo_out   <= quot_fix;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
